// File: rtl/hilo_unit_if.sv
// HI/LO unit bus: execute-stage request, mult/div result and HI/LO read-back.
// Purely structural; adds no latency.
// The execute stage holds its request while stallE is high.
interface hilo_unit_if;
    logic        flushE;
    logic        start;
    logic [2:0]  op;
    logic [31:0] wdata;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic        md_ok;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stallE;
    logic        busy;
    logic [31:0] md_count;

    modport master (
        output flushE, start, op, wdata, md_hi, md_lo, md_ok,
        input  hi, lo, stallE, busy, md_count
    );

    modport slave (
        input  flushE, start, op, wdata, md_hi, md_lo, md_ok,
        output hi, lo, stallE, busy, md_count
    );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register file with mult/div tracking FSM; HILO_BYPASS_EN enables same-cycle read forwarding.
// Latency: MTHI/MTLO and mult/div results land at the next edge; reads are combinational.
// Backpressure: stallE holds execute while a mult/div is pending; without bypass, MF after a write stalls one cycle.
module hilo_unit (
    input  logic        clk,
    input  logic        resetn,
    hilo_unit_if.slave  bus
);

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_MF    = 3'd7;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, lo_q, md_count_q;
    logic        hi_we, lo_we, cnt_inc;
    logic [31:0] hi_nxt, lo_nxt;
    logic        stall_c;
    logic        req_vld;
    logic        is_md;

    // Request qualifies only when not squashed; op 0 never does anything.
    assign req_vld = bus.start && !bus.flushE && (bus.op != OP_NONE);
    assign is_md   = (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);

`ifndef HILO_BYPASS_EN
    logic wr_last_q;
`endif

    // Next-state, HI/LO write enables and stall generation.
    always_comb begin
        state_d = state_q;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        hi_nxt  = hi_q;
        lo_nxt  = lo_q;
        cnt_inc = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    if (is_md) begin
                        state_d = BUSY;
                    end else if (bus.op == OP_MTHI) begin
                        hi_we  = 1'b1;
                        hi_nxt = bus.wdata;
                    end else if (bus.op == OP_MTLO) begin
                        lo_we  = 1'b1;
                        lo_nxt = bus.wdata;
                    end
`ifndef HILO_BYPASS_EN
                    // Registered read path: MF right after a write waits one cycle.
                    if (bus.op == OP_MF && wr_last_q) begin
                        stall_c = 1'b1;
                    end
`endif
                end
            end
            BUSY: begin
                // Start is ignored here; flush abandons the op even if the result is ready.
                if (bus.flushE) begin
                    state_d = IDLE;
                end else begin
                    stall_c = !bus.md_ok;
                    if (bus.md_ok) begin
                        hi_we   = 1'b1;
                        lo_we   = 1'b1;
                        hi_nxt  = bus.md_hi;
                        lo_nxt  = bus.md_lo;
                        cnt_inc = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, HI/LO and completion counter; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            md_count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (hi_we)   hi_q       <= hi_nxt;
            if (lo_we)   lo_q       <= lo_nxt;
            if (cnt_inc) md_count_q <= md_count_q + 32'd1;
        end
    end

`ifdef HILO_BYPASS_EN
    // Forward a write landing at the coming edge straight to the read port.
    assign bus.hi = hi_we ? hi_nxt : hi_q;
    assign bus.lo = lo_we ? lo_nxt : lo_q;
`else
    // Remember whether HI or LO was written at the last edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_last_q <= 1'b0;
        end else begin
            wr_last_q <= hi_we || lo_we;
        end
    end

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
`endif

    assign bus.stallE   = stall_c;
    assign bus.busy     = (state_q == BUSY);
    assign bus.md_count = md_count_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit with a queue-based scoreboard of expected values.
module tb_hilo_unit;

    logic clk;
    logic resetn;

    hilo_unit_if bus ();

    hilo_unit dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    int          n_cmp;
    int          n_err;

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                n_err++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
            end
        end
    endtask

    task automatic idle_inputs();
        bus.flushE = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 3'd0;
        bus.wdata  = 32'd0;
        bus.md_hi  = 32'd0;
        bus.md_lo  = 32'd0;
        bus.md_ok  = 1'b0;
    endtask

    int stall_n;

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        resetn = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Reset state
        push(32'd0); chk("rst_hi", bus.hi);
        push(32'd0); chk("rst_lo", bus.lo);
        push(32'd0); chk("rst_cnt", bus.md_count);
        push(32'd0); chk("rst_busy", {31'd0, bus.busy});
        push(32'd0); chk("rst_stall", {31'd0, bus.stallE});

        // MTHI
        bus.start = 1'b1; bus.op = 3'd5; bus.wdata = 32'h1234_5678;
        #1;
        push(32'd0); chk("mthi_stall", {31'd0, bus.stallE});
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'd0;
        #1;
        push(32'h1234_5678); chk("mthi_hi", bus.hi);
        push(32'd0);         chk("mthi_lo", bus.lo);
        push(32'd0);         chk("mthi_stall2", {31'd0, bus.stallE});

        // MULT with 32 waiting cycles; a held MTHI request during BUSY must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd1;
        #1;
        push(32'd0); chk("mult_issue_stall", {31'd0, bus.stallE});
        @(negedge clk);
        bus.op = 3'd5; bus.wdata = 32'hDEAD_BEEF;
        push(32'd1); chk("mult_busy", {31'd0, bus.busy});
        stall_n = 0;
        for (int i = 0; i < 32; i++) begin
            #1;
            if (bus.stallE === 1'b1) stall_n++;
            @(negedge clk);
        end
        push(32'd32); chk("mult_stall_cycles", stall_n);
        bus.md_ok = 1'b1; bus.md_hi = 32'hFFFF_FFFF; bus.md_lo = 32'hFFFF_FFFE;
        #1;
        push(32'd0); chk("mult_done_stall", {31'd0, bus.stallE});
        @(negedge clk);
        idle_inputs();
        #1;
        push(32'hFFFF_FFFF); chk("mult_hi", bus.hi);
        push(32'hFFFF_FFFE); chk("mult_lo", bus.lo);
        push(32'd1);         chk("mult_cnt", bus.md_count);
        push(32'd0);         chk("mult_busy_after", {31'd0, bus.busy});

        // DIV flushed in its 5th BUSY cycle while md_ok is high
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd3;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'd0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        bus.flushE = 1'b1; bus.md_ok = 1'b1;
        bus.md_hi = 32'h1111_1111; bus.md_lo = 32'h2222_2222;
        #1;
        push(32'd0); chk("flush_stall", {31'd0, bus.stallE});
        @(negedge clk);
        bus.flushE = 1'b0; bus.md_ok = 1'b0;
        #1;
        push(32'd0);         chk("flush_busy", {31'd0, bus.busy});
        push(32'hFFFF_FFFF); chk("flush_hi", bus.hi);
        push(32'hFFFF_FFFE); chk("flush_lo", bus.lo);
        push(32'd1);         chk("flush_cnt", bus.md_count);
        bus.md_ok = 1'b1;
        @(negedge clk);
        bus.md_ok = 1'b0;
        #1;
        push(32'hFFFF_FFFF); chk("late_ok_hi", bus.hi);
        push(32'd1);         chk("late_ok_cnt", bus.md_count);

        // MTLO followed by MF
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd6; bus.wdata = 32'hA5A5_A5A5;
        #1;
`ifdef HILO_BYPASS_EN
        push(32'hA5A5_A5A5);
`else
        push(32'hFFFF_FFFE);
`endif
        chk("mtlo_lo_same_cycle", bus.lo);
        @(negedge clk);
        bus.op = 3'd7; bus.wdata = 32'd0;
        #1;
`ifdef HILO_BYPASS_EN
        push(32'd0);
`else
        push(32'd1);
`endif
        chk("mf_stall", {31'd0, bus.stallE});
        push(32'hA5A5_A5A5); chk("mf_lo", bus.lo);
        @(negedge clk);
        #1;
        push(32'd0);         chk("mf_stall_next", {31'd0, bus.stallE});
        push(32'hA5A5_A5A5); chk("mf_lo_next", bus.lo);
        @(negedge clk);
        idle_inputs();

        // Reset in the middle of BUSY
        bus.start = 1'b1; bus.op = 3'd4;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'd0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        push(32'd0); chk("mid_rst_busy", {31'd0, bus.busy});
        push(32'd0); chk("mid_rst_hi", bus.hi);
        push(32'd0); chk("mid_rst_lo", bus.lo);
        push(32'd0); chk("mid_rst_cnt", bus.md_count);
        push(32'd0); chk("mid_rst_stall", {31'd0, bus.stallE});

        // start together with flushE stays IDLE
        bus.start = 1'b1; bus.flushE = 1'b1; bus.op = 3'd2;
        #1;
        push(32'd0); chk("flush_start_stall", {31'd0, bus.stallE});
        @(negedge clk);
        idle_inputs();
        #1;
        push(32'd0); chk("flush_start_busy", {31'd0, bus.busy});

        // Counter wrap from 0xFFFFFFFF
        @(negedge clk);
        force dut.md_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.md_count_q;
        #1;
        push(32'hFFFF_FFFF); chk("preload_cnt", bus.md_count);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd2;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'd0;
        bus.md_ok = 1'b1; bus.md_hi = 32'h0000_0001; bus.md_lo = 32'h8000_0000;
        @(negedge clk);
        idle_inputs();
        #1;
        push(32'd0);         chk("wrap_cnt", bus.md_count);
        push(32'h0000_0001); chk("wrap_hi", bus.hi);
        push(32'h8000_0000); chk("wrap_lo", bus.lo);
        push(32'd0);         chk("wrap_busy", {31'd0, bus.busy});

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
